// File: rtl/ppwm_prog_mem_if.sv
// Load/read bus of one PWM channel's instruction store: serial load pins plus
// the executor's program-counter read port and load status.
interface ppwm_prog_mem_if #(
    parameter int INSTR_WIDTH = 7,
    parameter int PC_WIDTH    = 4
);
    logic                   ld_sclk_i;
    logic                   ld_cs_ni;
    logic                   ld_sdi_i;
    logic [PC_WIDTH-1:0]    pc_i;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic                   load_active_o;
    logic [PC_WIDTH:0]      wr_count_o;

    modport master (
        output ld_sclk_i, ld_cs_ni, ld_sdi_i, pc_i,
        input  instr_o, load_active_o, wr_count_o
    );

    modport slave (
        input  ld_sclk_i, ld_cs_ni, ld_sdi_i, pc_i,
        output instr_o, load_active_o, wr_count_o
    );
endinterface

// File: rtl/ppwm_prog_mem.sv
// PWM channel instruction store: combinational read at pc_i, written through a
// clk-synchronised serial port (start-address header, auto-increment burst).
module ppwm_prog_mem #(
    parameter int INSTR_WIDTH = 7,
    parameter int PC_WIDTH    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ppwm_prog_mem_if.slave bus
);
    localparam int DEPTH = 2**PC_WIDTH;
    localparam int CNT_W = $clog2(INSTR_WIDTH + 1);
    localparam int SH_W  = INSTR_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state, state_nxt;
    logic                   sclk_p0, sclk_p1, sclk_p2;
    logic                   cs_p0, cs_p1;
    logic                   sdi_p0, sdi_p1;
    logic                   bit_stb;
    logic                   hdr_last, word_last, take_bit, do_write;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SH_W-1:0]        shift;
    logic [PC_WIDTH-1:0]    addr;
    logic [PC_WIDTH:0]      wr_count;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    function automatic logic [PC_WIDTH:0] sat_inc(input logic [PC_WIDTH:0] v);
        if (v >= (PC_WIDTH+1)'(DEPTH))
            return v;
        return v + (PC_WIDTH+1)'(1);
    endfunction

    // p0/p1: two-flop synchronisers; p2 delays sclk for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            sdi_p0  <= 1'b0;
            sdi_p1  <= 1'b0;
        end else begin
            sclk_p0 <= bus.ld_sclk_i;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= bus.ld_cs_ni;
            cs_p1   <= cs_p0;
            sdi_p0  <= bus.ld_sdi_i;
            sdi_p1  <= sdi_p0;
        end
    end

    assign bit_stb   = sclk_p1 & ~sclk_p2;
    assign hdr_last  = (bit_cnt == CNT_W'(PC_WIDTH - 1));
    assign word_last = (bit_cnt == CNT_W'(INSTR_WIDTH - 1));
    // A deselect in the strobe cycle swallows the bit, so no write can sneak out
    assign take_bit  = (state != IDLE) && !cs_p1 && bit_stb;
    assign do_write  = take_bit && (state == DATA) && word_last;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!cs_p1) state_nxt = ADDR;
            ADDR:    if (cs_p1) state_nxt = IDLE;
                     else if (bit_stb && hdr_last) state_nxt = DATA;
            DATA:    if (cs_p1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            addr     <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            wr_count <= '0;
        end else if (state == IDLE && !cs_p1) begin
            bit_cnt  <= '0;
            wr_count <= '0;
        end else if (take_bit) begin
            if ((state == ADDR && hdr_last) || do_write) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                shift   <= {shift[SH_W-2:0], sdi_p1};
            end
            if (state == ADDR && hdr_last)
                addr <= {shift[PC_WIDTH-2:0], sdi_p1};
            if (do_write) begin
                mem[addr] <= {shift, sdi_p1};
                addr      <= addr + PC_WIDTH'(1);
                wr_count  <= sat_inc(wr_count);
            end
        end
    end

    assign bus.instr_o       = mem[bus.pc_i];
    assign bus.load_active_o = (state != IDLE);
    assign bus.wr_count_o    = wr_count;
endmodule

// File: tb/tb_ppwm_prog_mem.sv
// Scoreboard bench for ppwm_prog_mem: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ppwm_prog_mem;
    localparam int IW = 7;
    localparam int PW = 4;

    typedef struct {
        int       kind;   // 0 instr, 1 load_active, 2 wr_count
        logic [7:0] exp;
        string    name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ppwm_prog_mem_if #(.INSTR_WIDTH(IW), .PC_WIDTH(PW)) bus ();

    ppwm_prog_mem #(.INSTR_WIDTH(IW), .PC_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [IW-1:0] model [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       check(e.name, {1'b0, bus.instr_o}, e.exp);
                1:       check(e.name, {7'b0, bus.load_active_o}, e.exp);
                default: check(e.name, {3'b0, bus.wr_count_o}, e.exp);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [7:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic expect_instr(input int pc);
        bus.pc_i = PW'(pc);
        push(0, {1'b0, model[pc]}, $sformatf("instr[%0d]", pc));
        tick(1);
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++)
            expect_instr(i);
    endtask

    task automatic expect_status(input logic la, input logic [PW:0] wc, input string tag);
        push(1, {7'b0, la}, {tag, ".load_active"});
        push(2, {3'b0, wc}, {tag, ".wr_count"});
        tick(1);
    endtask

    task automatic send_bit(input logic b);
        bus.ld_sdi_i = b;
        tick(5);
        bus.ld_sclk_i = 1'b1;
        tick(5);
        bus.ld_sclk_i = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i]);
    endtask

    task automatic frame_start();
        bus.ld_cs_ni = 1'b0;
        tick(5);
    endtask

    task automatic frame_end();
        tick(5);
        bus.ld_cs_ni = 1'b1;
        tick(6);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [IW-1:0] prev_instr;
        logic          seen;
        bus.ld_sclk_i = 1'b0;
        bus.ld_cs_ni  = 1'b1;
        bus.ld_sdi_i  = 1'b0;
        bus.pc_i      = '0;
        for (int i = 0; i < 16; i++)
            model[i] = '0;
        tick(4);
        rst_n = 1'b1;
        tick(1);

        // Reset contents
        expect_status(1'b0, 5'd0, "reset");
        sweep();

        // Single write: header 0011, data 1010101
        frame_start();
        send_bits(8'h03, 4);
        send_bits(8'h55, 7);
        tick(5);
        bus.ld_cs_ni = 1'b1;
        tick(2);
        push(1, 8'd1, "single.load_active_hold");
        tick(1);
        push(1, 8'd0, "single.load_active_fall");
        tick(3);
        model[3] = 7'h55;
        expect_status(1'b0, 5'd1, "single");
        sweep();

        // Burst with wrap: header 1110, words 0x11 0x22 0x33
        frame_start();
        send_bits(8'h0E, 4);
        send_bits(8'h11, 7);
        send_bits(8'h22, 7);
        send_bits(8'h33, 7);
        frame_end();
        model[14] = 7'h11;
        model[15] = 7'h22;
        model[0]  = 7'h33;
        expect_status(1'b0, 5'd3, "burst");
        sweep();

        // Partial word: header 0101, 0x7F, then 4 bits, deselect
        frame_start();
        send_bits(8'h05, 4);
        send_bits(8'h7F, 7);
        send_bits(8'h0A, 4);
        frame_end();
        model[5] = 7'h7F;
        expect_status(1'b0, 5'd1, "partial");
        sweep();
        frame_start();
        send_bits(8'h06, 4);
        send_bits(8'h46, 7);
        frame_end();
        model[6] = 7'h46;
        expect_status(1'b0, 5'd1, "partial_refill");
        sweep();

        // Read during write: pc held at 2 while 0x2A (0101010) lands at address 2
        bus.pc_i = 4'd2;
        frame_start();
        send_bits(8'h02, 4);
        for (int i = 6; i >= 1; i--)
            send_bit(1'(8'h2A >> i));
        bus.ld_sdi_i = 1'b0;
        tick(5);
        bus.ld_sclk_i = 1'b1;
        prev_instr = 7'h7F;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (bus.wr_count_o == 5'd1) begin
                seen = 1'b1;
                check("rdw.write_cycle_old", {1'b0, prev_instr}, 8'h00);
                check("rdw.next_cycle_new", {1'b0, bus.instr_o}, 8'h2A);
            end else begin
                prev_instr = bus.instr_o;
            end
        end
        if (!seen)
            check("rdw.write_timeout", 8'd0, 8'd1);
        tick(5);
        bus.ld_sclk_i = 1'b0;
        frame_end();
        model[2] = 7'h2A;
        expect_instr(9);
        expect_status(1'b0, 5'd1, "rdw");
        sweep();

        // Reset mid-frame: address 4 written, then 5 more bits, then reset
        frame_start();
        send_bits(8'h04, 4);
        send_bits(8'h3C, 7);
        model[4] = 7'h3C;
        expect_instr(4);
        send_bits(8'h1F, 5);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            model[i] = '0;
        expect_status(1'b0, 5'd0, "midreset");
        sweep();
        send_bits(8'h08, 4);
        send_bits(8'h5A, 7);
        frame_end();
        model[8] = 7'h5A;
        expect_status(1'b0, 5'd1, "after_reset");
        sweep();

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
